// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg
// Definitions shared by the change dispenser and its coin selector. The
// denomination values match the insertion-side money decode of the vending
// controller, so a coin ejected here is the same value as one accepted there.
// No ports (package).
package change_dispenser_pkg;

  // Coin denominations in money units.
  localparam logic [7:0] DENOM_FIFTY  = 8'd50;
  localparam logic [7:0] DENOM_TWENTY = 8'd20;
  localparam logic [7:0] DENOM_TEN    = 8'd10;
  localparam logic [7:0] DENOM_FIVE   = 8'd5;
  localparam logic [7:0] DENOM_ONE    = 8'd1;

  // Bit positions of each denomination in the one-hot coin vector.
  localparam int NUM_COINS   = 5;
  localparam int COIN_FIFTY  = 4;
  localparam int COIN_TWENTY = 3;
  localparam int COIN_TEN    = 2;
  localparam int COIN_FIVE   = 1;
  localparam int COIN_ONE    = 0;

  // Dispenser FSM encodings.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } disp_state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// change_dispenser_coin_select
// Combinational greedy selector: picks the largest denomination that does not
// exceed the remaining amount, checked 50, 20, 10, 5, 1.
// Ports:
//   remain      in  8  amount still to dispense
//   coin_onehot out 5  one-hot denomination (all zero when remain is 0)
//   coin_value  out 8  value of the selected denomination (0 when remain is 0)
module change_dispenser_coin_select
  import change_dispenser_pkg::*;
(
  input  logic [7:0]           remain,
  output logic [NUM_COINS-1:0] coin_onehot,
  output logic [7:0]           coin_value
);

  always_comb begin
    coin_onehot = '0;
    coin_value  = '0;
    if (remain >= DENOM_FIFTY) begin
      coin_onehot[COIN_FIFTY] = 1'b1;
      coin_value              = DENOM_FIFTY;
    end else if (remain >= DENOM_TWENTY) begin
      coin_onehot[COIN_TWENTY] = 1'b1;
      coin_value               = DENOM_TWENTY;
    end else if (remain >= DENOM_TEN) begin
      coin_onehot[COIN_TEN] = 1'b1;
      coin_value            = DENOM_TEN;
    end else if (remain >= DENOM_FIVE) begin
      coin_onehot[COIN_FIVE] = 1'b1;
      coin_value             = DENOM_FIVE;
    end else if (remain >= DENOM_ONE) begin
      coin_onehot[COIN_ONE] = 1'b1;
      coin_value            = DENOM_ONE;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
// Turns a change amount into a train of one-cycle coin-ejector pulses using
// greedy decomposition, with GAP_CYCLES idle cycles after each coin.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | selecting next coin; pulse appears the following cycle
// GAP   | spacing between coins, gap counter runs down to 1
// DONE  | one-cycle completion (done high), then back to IDLE
//
// Ports:
//   sys_clk, sys_rst_n   clock, async active-low reset
//   start, change_money  request and amount (latched in IDLE)
//   abort                stop dispensing (ISSUE/GAP only)
//   out_money_*          one-cycle coin pulses
//   remain_money         amount not yet dispensed
//   coin_count           coins issued since last accepted start
//   busy, done           activity flag, completion pulse
module change_dispenser #(
  parameter int GAP_CYCLES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] change_money,
  input  logic       abort,
  output logic       out_money_fifty,
  output logic       out_money_twenty,
  output logic       out_money_ten,
  output logic       out_money_five,
  output logic       out_money_one,
  output logic [7:0] remain_money,
  output logic [3:0] coin_count,
  output logic       busy,
  output logic       done
);

  import change_dispenser_pkg::*;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  disp_state_t          state, state_nxt;
  logic [7:0]           remain_nxt;
  logic [3:0]           count_nxt;
  logic [3:0]           gap_cnt, gap_nxt;
  logic [NUM_COINS-1:0] coin_q, coin_nxt;
  logic                 busy_nxt, done_nxt;

  logic [NUM_COINS-1:0] sel_onehot;
  logic [7:0]           sel_value;

  change_dispenser_coin_select u_coin_select (
    .remain      (remain_money),
    .coin_onehot (sel_onehot),
    .coin_value  (sel_value)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      remain_money <= '0;
      coin_count   <= '0;
      gap_cnt      <= '0;
      coin_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      remain_money <= remain_nxt;
      coin_count   <= count_nxt;
      gap_cnt      <= gap_nxt;
      coin_q       <= coin_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    remain_nxt = remain_money;
    count_nxt  = coin_count;
    gap_nxt    = gap_cnt;
    coin_nxt   = '0;
    done_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          remain_nxt = change_money;
          count_nxt  = '0;
          if (change_money != 8'd0) begin
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          coin_nxt   = sel_onehot;
          remain_nxt = remain_money - sel_value;
          count_nxt  = coin_count + 4'd1;
          // done is registered alongside the last coin so both land in the
          // same cycle.
          if (remain_nxt == 8'd0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          if (gap_cnt <= 4'd1) begin
            state_nxt = ST_ISSUE;
          end
          if (gap_cnt != 4'd0) begin
            gap_nxt = gap_cnt - 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign out_money_fifty  = coin_q[COIN_FIFTY];
  assign out_money_twenty = coin_q[COIN_TWENTY];
  assign out_money_ten    = coin_q[COIN_TEN];
  assign out_money_five   = coin_q[COIN_FIVE];
  assign out_money_one    = coin_q[COIN_ONE];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
// Self-checking bench: directed and random change requests compared cycle by
// cycle against a coin-list timing model.
module tb_change_dispenser;

  localparam int G = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] change_money = 8'd0;
  logic       out_money_fifty, out_money_twenty, out_money_ten;
  logic       out_money_five, out_money_one;
  logic [7:0] remain_money;
  logic [3:0] coin_count;
  logic       busy, done;

  change_dispenser #(.GAP_CYCLES(G)) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .start            (start),
    .change_money     (change_money),
    .abort            (abort),
    .out_money_fifty  (out_money_fifty),
    .out_money_twenty (out_money_twenty),
    .out_money_ten    (out_money_ten),
    .out_money_five   (out_money_five),
    .out_money_one    (out_money_one),
    .remain_money     (remain_money),
    .coin_count       (coin_count),
    .busy             (busy),
    .done             (done)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0] pulse;   // {50,20,10,5,1}
    logic       done;
    logic       busy;
    int         remain;
    int         count;
  } exp_t;

  int coins[$];

  function automatic logic [4:0] pulse_of(input int d);
    case (d)
      50:      return 5'b10000;
      20:      return 5'b01000;
      10:      return 5'b00100;
      5:       return 5'b00010;
      default: return 5'b00001;
    endcase
  endfunction

  function automatic void build_coins(input int amt);
    int denoms[5] = '{50, 20, 10, 5, 1};
    int rem = amt;
    coins.delete();
    foreach (denoms[i]) begin
      repeat (rem / denoms[i]) coins.push_back(denoms[i]);
      rem = rem % denoms[i];
    end
  endfunction

  // Expected outputs in cycle t of an uninterrupted run (start high in cycle 0).
  function automatic exp_t model_at(input int amt, input int t);
    exp_t e;
    int n = coins.size();
    int last = (n == 0) ? 1 : 2 + (n - 1) * (G + 1);
    e.pulse = '0;
    e.done = (t == last);
    e.busy = (t >= 1 && t <= last);
    e.remain = amt;
    e.count = 0;
    for (int k = 0; k < n; k++) begin
      int ck = 2 + k * (G + 1);
      if (t >= ck) begin
        e.remain -= coins[k];
        e.count = k + 1;
      end
      if (t == ck) e.pulse = pulse_of(coins[k]);
    end
    return e;
  endfunction

  function automatic logic [4:0] obs_pulse();
    return {out_money_fifty, out_money_twenty, out_money_ten, out_money_five, out_money_one};
  endfunction

  function automatic int last_cycle();
    return (coins.size() == 0) ? 1 : 2 + (coins.size() - 1) * (G + 1);
  endfunction

  // a: cycle in which abort is high (-1 none); s: cycle of a stray start (-1 none)
  task automatic run_txn(input int amt, input int a, input int s);
    int last;
    int stop;
    bit aborted;
    exp_t e;
    build_coins(amt);
    last = last_cycle();
    aborted = (coins.size() > 0) && (a >= 1) && (a < last);
    stop = aborted ? a + 2 : last + 2;
    @(negedge sys_clk);
    change_money = 8'(amt);
    start = 1'b1;
    abort = 1'b0;
    for (int t = 1; t <= stop; t++) begin
      @(negedge sys_clk);
      if (aborted && t > a) begin
        e = model_at(amt, a);
        e.pulse = '0;
        e.done = 1'b0;
        e.busy = 1'b0;
      end else begin
        e = model_at(amt, t);
      end
      check($sformatf("amt%0d c%0d pulse/done/busy", amt, t),
            {25'd0, obs_pulse(), done, busy}, {25'd0, e.pulse, e.done, e.busy});
      check($sformatf("amt%0d c%0d remain", amt, t), {24'd0, remain_money}, e.remain);
      check($sformatf("amt%0d c%0d count", amt, t), {28'd0, coin_count}, e.count);
      start = (t == s);
      abort = (t == a);
      if (t == s) change_money = 8'd7;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic reset_mid_run(input int amt, input int cyc);
    exp_t e;
    build_coins(amt);
    @(negedge sys_clk);
    change_money = 8'(amt);
    start = 1'b1;
    for (int t = 1; t <= cyc; t++) begin
      @(negedge sys_clk);
      start = 1'b0;
    end
    e = model_at(amt, cyc);
    check($sformatf("rst amt%0d c%0d pre pulse", amt, cyc), {27'd0, obs_pulse()}, {27'd0, e.pulse});
    sys_rst_n = 1'b0;
    #1;
    check($sformatf("rst amt%0d c%0d outputs", amt, cyc),
          {13'd0, obs_pulse(), remain_money, coin_count, busy, done}, 32'd0);
    @(negedge sys_clk);
    check("rst held outputs", {13'd0, obs_pulse(), remain_money, coin_count, busy, done}, 32'd0);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int amt;
    int a;
    int s;
    int last;
    repeat (3) @(negedge sys_clk);
    check("reset outputs", {13'd0, obs_pulse(), remain_money, coin_count, busy, done}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle after reset", {13'd0, obs_pulse(), remain_money, coin_count, busy, done}, 32'd0);

    run_txn(86, -1, -1);
    run_txn(99, -1, -1);
    run_txn(0, -1, -1);
    run_txn(255, -1, -1);
    run_txn(249, -1, -1);
    run_txn(99, 8, 3);    // abort in gap after second coin, stray start earlier
    run_txn(1, -1, 1);
    run_txn(50, 1, -1);   // abort while still in first ISSUE

    reset_mid_run(99, 4);  // mid-gap
    run_txn(37, -1, -1);
    reset_mid_run(86, 7);  // on the second coin pulse
    run_txn(86, -1, -1);

    for (int i = 0; i < 25; i++) begin
      amt = (i % 6 == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
      build_coins(amt);
      last = last_cycle();
      a = -1;
      s = -1;
      if (coins.size() > 0 && $urandom_range(0, 1) == 1) a = $urandom_range(1, last - 1);
      if ($urandom_range(0, 2) == 0) s = $urandom_range(1, (a > 0) ? a : last);
      run_txn(amt, a, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
